mixer_level_ramp: RTL and testbench



---
 rtl/mixer_level_ramp.sv | 130 +++++++++++++
 tb/tb_mixer_level_ramp.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mixer_level_ramp.sv
// Volume sequencer: steps the mixer level toward a requested target, one level per
// FRAMES_PER_STEP lrclk frames, with soft mute ramping down to 0 and back.
module mixer_level_ramp #(
    parameter int unsigned MAX_LEVEL       = 82,
    parameter int unsigned FRAMES_PER_STEP = 4,
    parameter int unsigned w_cnt           = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       lrclk,
    input  logic [6:0] target_level,
    input  logic       target_valid,
    output logic       target_ready,
    input  logic       mute,
    output logic [6:0] level,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RAMP  = 2'd1,
        ST_MUTED = 2'd2
    } state_e;

    localparam logic [6:0]       MAX_LVL  = 7'(MAX_LEVEL);
    localparam logic [w_cnt-1:0] LAST_CNT = w_cnt'(FRAMES_PER_STEP - 1);

    logic             sync1_q, sync2_q, hist_q, tick_q;
    logic [1:0]       arm_q;
    state_e           state_q, state_d;
    logic [6:0]       tgt_q, tgt_d;
    logic [6:0]       level_q, level_d;
    logic [w_cnt-1:0] fcnt_q, fcnt_d;
    logic             done_q, done_d;

    logic [6:0] tgt_new, goal, goal_n;
    logic       accept;

    // The edge history is held at 1 until the synchronizer carries real samples,
    // so an lrclk already high at reset release is not taken as a rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            arm_q   <= '0;
            hist_q  <= 1'b1;
            tick_q  <= 1'b0;
        end else begin
            sync1_q <= lrclk;
            sync2_q <= sync1_q;
            arm_q   <= {arm_q[0], 1'b1};
            hist_q  <= arm_q[1] ? sync2_q : 1'b1;
            tick_q  <= arm_q[1] & sync2_q & ~hist_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            tgt_q   <= '0;
            level_q <= '0;
            fcnt_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            level_q <= level_d;
            fcnt_q  <= fcnt_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        level_d = level_q;
        fcnt_d  = fcnt_q;
        done_d  = 1'b0;
        goal_n  = '0;
        tgt_new = (target_level > MAX_LVL) ? MAX_LVL : target_level;
        accept  = target_valid && (state_q != ST_RAMP);
        goal    = mute ? '0 : tgt_q;

        case (state_q)
            ST_IDLE, ST_MUTED: begin
                fcnt_d = '0;
                if (accept) begin
                    tgt_d = tgt_new;
                end
                goal_n = mute ? '0 : tgt_d;
                if (level_q != goal_n) begin
                    state_d = ST_RAMP;
                end else if (mute) begin
                    state_d = ST_MUTED;
                end else begin
                    state_d = ST_IDLE;
                    done_d  = (state_q == ST_MUTED);
                end
            end
            ST_RAMP: begin
                if (tick_q) begin
                    if (fcnt_q == LAST_CNT) begin
                        fcnt_d = '0;
                        if (level_q < goal) begin
                            level_d = level_q + 7'd1;
                        end else if (level_q > goal) begin
                            level_d = level_q - 7'd1;
                        end
                    end else begin
                        fcnt_d = fcnt_q + w_cnt'(1);
                    end
                end
                // Exit on the same edge as the final step so done and busy align.
                if (level_d == goal) begin
                    state_d = mute ? ST_MUTED : ST_IDLE;
                    done_d  = !mute;
                    fcnt_d  = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign target_ready = (state_q != ST_RAMP);
    assign busy         = (state_q == ST_RAMP);
    assign level        = level_q;
    assign done         = done_q;

endmodule

// File: tb/tb_mixer_level_ramp.sv
// Scoreboard bench for mixer_level_ramp: stimulus queues expected level steps and
// done pulses; a monitor checks them, their frame alignment and the step rate.
module tb_mixer_level_ramp;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       lrclk;
    logic [6:0] target_level;
    logic       target_valid;
    logic       target_ready;
    logic       mute;
    logic [6:0] level;
    logic       busy;
    logic       done;

    always #5 clk = ~clk;

    mixer_level_ramp #(
        .MAX_LEVEL      (82),
        .FRAMES_PER_STEP(4),
        .w_cnt          (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .lrclk       (lrclk),
        .target_level(target_level),
        .target_valid(target_valid),
        .target_ready(target_ready),
        .mute        (mute),
        .level       (level),
        .busy        (busy),
        .done        (done)
    );

    typedef struct {
        bit is_done;
        int val;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    bit   lr_en   = 1'b0;
    bit   lr_hold = 1'b0;
    bit   mute_clr = 1'b1;

    int   cyc = 0;
    int   pend = -1;
    int   last_tick = -100;
    int   ticks_since = 0;

    task automatic check(input string name, input bit ok, input int act, input int exp_v);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
    endtask

    task automatic push_lvls(input int from_v, input int to_v);
        exp_t e;
        e.is_done = 1'b0;
        if (from_v <= to_v) begin
            for (int v = from_v; v <= to_v; v++) begin e.val = v; exp_q.push_back(e); end
        end else begin
            for (int v = from_v; v >= to_v; v--) begin e.val = v; exp_q.push_back(e); end
        end
    endtask

    task automatic push_done();
        exp_t e;
        e.is_done = 1'b1;
        e.val     = 0;
        exp_q.push_back(e);
    endtask

    task automatic send(input int t);
        int i;
        @(negedge clk);
        target_level = 7'(t);
        target_valid = 1'b1;
        i = 0;
        do begin
            @(posedge clk);
            i++;
        end while (!target_ready && i < 200);
        @(negedge clk);
        target_valid = 1'b0;
        if (i >= 200) check("send_timeout", 1'b0, 0, 1);
    endtask

    task automatic wait_level(input int v, input int budget);
        for (int i = 0; i < budget && level != 7'(v); i++) @(negedge clk);
        check("reach_level", level == 7'(v), int'(level), v);
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
        check("drain", exp_q.size() == 0, exp_q.size(), 0);
        @(negedge clk);
    endtask

    // lrclk: edges land 1-4 time units after a falling clk edge, never on a rising one.
    initial begin
        int half;
        half  = 4;
        lrclk = 1'b0;
        forever begin
            @(negedge clk);
            if (!lr_en) begin
                lrclk = lr_hold;
            end else if (half == 0) begin
                #($urandom_range(1, 4));
                lrclk = ~lrclk;
                half  = $urandom_range(3, 5);
            end else begin
                half--;
            end
        end
    end

    // Monitor: tick k arrives 3 edges after the edge that first samples lrclk high.
    initial begin
        exp_t e;
        bit   lr_prev;
        bit   mute_prev;
        logic [6:0] lvl_prev;
        lr_prev   = 1'b0;
        mute_prev = 1'b0;
        lvl_prev  = '0;
        forever begin
            @(posedge clk);
            cyc++;
            if (!rst_n) begin
                pend      = -1;
                lr_prev   = lrclk;
                mute_prev = mute;
            end else begin
                if (cyc == pend) begin
                    ticks_since++;
                    last_tick = cyc;
                end
                if (lrclk && !lr_prev) pend = cyc + 3;
                lr_prev = lrclk;
                if (target_valid && target_ready) ticks_since = 0;
                if (mute != mute_prev && mute_clr) ticks_since = 0;
                mute_prev = mute;
            end
            #1;
            if (!rst_n) begin
                lvl_prev = level;
            end else begin
                if (level != lvl_prev) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_level", 1'b0, int'(level), int'(lvl_prev));
                    end else begin
                        e = exp_q.pop_front();
                        check("level_step", !e.is_done && int'(level) == e.val, int'(level), e.is_done ? -1 : e.val);
                    end
                    check("frame_align", last_tick == cyc, cyc - last_tick, 0);
                    check("frames_per_step", ticks_since == 4, ticks_since, 4);
                    ticks_since = 0;
                    lvl_prev = level;
                end
                if (done) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_done", 1'b0, 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("done_order", e.is_done, int'(e.is_done), 1);
                    end
                    check("busy_at_done", !busy, int'(busy), 0);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n        = 1'b0;
        target_valid = 1'b0;
        target_level = '0;
        mute         = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_level", level == 7'd0, int'(level), 0);
        check("reset_ready", target_ready == 1'b1, int'(target_ready), 1);
        check("reset_busy", busy == 1'b0, int'(busy), 0);
        check("reset_done", done == 1'b0, int'(done), 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        lr_en = 1'b1;
        repeat (5) @(negedge clk);

        // Basic ramp up 0 -> 10
        push_lvls(1, 10); push_done();
        send(10);
        check("ramp_ready_low", target_ready == 1'b0, int'(target_ready), 0);
        check("ramp_busy", busy == 1'b1, int'(busy), 1);
        wait_level(5, 400);
        check("mid_ramp_ready_low", target_ready == 1'b0, int'(target_ready), 0);
        wait_drain(400);

        // Clamp to 82, then down to 80
        push_lvls(11, 82); push_done();
        send(100);
        wait_drain(72 * 60 + 100);
        check("clamp_level", level == 7'd82, int'(level), 82);
        push_lvls(81, 80); push_done();
        send(80);
        wait_drain(300);

        // Soft mute round trip from 20
        push_lvls(79, 20); push_done();
        send(20);
        wait_drain(60 * 60 + 100);
        push_lvls(19, 0);
        mute_clr = 1'b1;
        @(negedge clk) mute = 1'b1;
        wait_drain(20 * 60 + 100);
        check("muted_busy", busy == 1'b0, int'(busy), 0);
        check("muted_ready", target_ready == 1'b1, int'(target_ready), 1);
        send(30);
        repeat (60) @(negedge clk);
        check("muted_level_held", level == 7'd0, int'(level), 0);
        check("muted_still_idle", busy == 1'b0, int'(busy), 0);
        push_lvls(1, 30); push_done();
        @(negedge clk) mute = 1'b0;
        wait_drain(30 * 60 + 100);

        // Mute reversal mid-ramp
        push_lvls(29, 0); push_done();
        send(0);
        wait_drain(30 * 60 + 100);
        push_lvls(1, 7);
        send(20);
        wait_level(7, 7 * 60 + 100);
        for (int i = 0; i < 100 && ticks_since != 2; i++) @(negedge clk);
        check("mid_count_reached", ticks_since == 2, ticks_since, 2);
        mute_clr = 1'b0;
        push_lvls(6, 3);
        mute = 1'b1;
        wait_level(3, 4 * 60 + 100);
        push_lvls(4, 20); push_done();
        mute = 1'b0;
        wait_drain(17 * 60 + 100);
        mute_clr = 1'b1;

        // Asynchronous reset mid-ramp, lrclk held high through release
        push_lvls(19, 15);
        send(0);
        wait_level(15, 5 * 60 + 100);
        #2;
        rst_n   = 1'b0;
        lr_en   = 1'b0;
        lr_hold = 1'b1;
        #1;
        check("async_rst_level", level == 7'd0, int'(level), 0);
        check("async_rst_busy", busy == 1'b0, int'(busy), 0);
        check("async_rst_ready", target_ready == 1'b1, int'(target_ready), 1);
        check("async_rst_done", done == 1'b0, int'(done), 0);
        check("async_rst_queue", exp_q.size() == 0, exp_q.size(), 0);
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b1;
        push_lvls(1, 1); push_done();
        send(1);
        repeat (8) @(negedge clk);
        check("no_spurious_tick_level", level == 7'd0, int'(level), 0);
        lr_en = 1'b1;
        wait_drain(200);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
